// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions: slot record layout, field widths and the
// forwarding-mux encodings used by the EX-stage operand selectors.
package hazard_scoreboard_pkg;

  localparam int REG_IDX_W   = 5;
  localparam int STALL_CNT_W = 16;

  typedef struct packed {
    logic                 valid;
    logic                 regwrite;
    logic                 is_load;
    logic [REG_IDX_W-1:0] rd;
  } slot_t;

  localparam int    SLOT_W      = $bits(slot_t);
  localparam slot_t SLOT_BUBBLE = '0;

  typedef enum logic [1:0] {
    FWD_NONE   = 2'b00,
    FWD_MEM_WB = 2'b01,
    FWD_EX_MEM = 2'b10
  } fwd_sel_t;

  function automatic logic slot_writes(input slot_t s);
    return s.valid && s.regwrite;
  endfunction

  // The younger producer (MEM) takes priority over WB for the same register.
  function automatic fwd_sel_t fwd_select(input logic [REG_IDX_W-1:0] rs,
                                          input slot_t mem, input slot_t wb);
    if (slot_writes(mem) && mem.rd == rs) return FWD_EX_MEM;
    if (slot_writes(wb) && wb.rd == rs)   return FWD_MEM_WB;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_slot.sv
// One pipeline tracking slot: a resettable register of a slot record that
// holds its contents while the pipeline is frozen.
module scoreboard_slot
  import hazard_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_hold,
  input  logic [SLOT_W-1:0] i_d,
  output logic [SLOT_W-1:0] o_q
);

  logic [SLOT_W-1:0] r_q;

  // NOTE: sequential state uses non-blocking assignments so every slot samples
  // its neighbour's pre-edge value; blocking here would collapse the shift chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (!i_hold) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard detection for a 5-stage pipeline: tracks EX/MEM/WB
// destinations, raises stall on a load-use pair and exports forwarding info.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [REG_IDX_W-1:0]   id_rs1,
  input  logic [REG_IDX_W-1:0]   id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [REG_IDX_W-1:0]   id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_is_load,
  input  logic                   flush,
  input  logic                   freeze,
  output logic                   stall,
  output logic                   ex_mem_regwrite,
  output logic [REG_IDX_W-1:0]   ex_mem_rd,
  output logic                   mem_wb_regwrite,
  output logic [REG_IDX_W-1:0]   mem_wb_rd,
  output logic [STALL_CNT_W-1:0] stall_count
);

  slot_t                  w_ex, w_mem, w_wb;
  slot_t                  w_id_slot, w_ex_next;
  logic                   w_rs1_hit, w_rs2_hit, w_stall, w_count_en;
  logic                   w_unused;
  logic [STALL_CNT_W-1:0] r_stall_count;

  assign w_rs1_hit = id_uses_rs1 && (id_rs1 == w_ex.rd);
  assign w_rs2_hit = id_uses_rs2 && (id_rs2 == w_ex.rd);
  assign w_stall   = id_valid && w_ex.valid && w_ex.is_load && w_ex.regwrite
                     && (w_rs1_hit || w_rs2_hit);

  // NOTE: every field gets a default before any conditional update so the
  // block stays purely combinational and no latch is inferred.
  always_comb begin
    w_id_slot          = SLOT_BUBBLE;
    w_id_slot.valid    = 1'b1;
    w_id_slot.regwrite = id_regwrite && (id_rd != '0);
    w_id_slot.is_load  = id_is_load;
    w_id_slot.rd       = id_rd;
    w_ex_next          = (id_valid && !w_stall && !flush) ? w_id_slot : SLOT_BUBBLE;
  end

  scoreboard_slot u_ex_slot (
    .clk    (clk),
    .reset  (reset),
    .i_hold (freeze),
    .i_d    (w_ex_next),
    .o_q    (w_ex)
  );

  scoreboard_slot u_mem_slot (
    .clk    (clk),
    .reset  (reset),
    .i_hold (freeze),
    .i_d    (w_ex),
    .o_q    (w_mem)
  );

  scoreboard_slot u_wb_slot (
    .clk    (clk),
    .reset  (reset),
    .i_hold (freeze),
    .i_d    (w_mem),
    .o_q    (w_wb)
  );

  // A stall that coincides with a flush is absorbed by the flush bubble.
  assign w_count_en = w_stall && !flush && !freeze && (r_stall_count != '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_count_en) begin
      r_stall_count <= r_stall_count + STALL_CNT_W'(1);
    end
  end

  assign stall           = w_stall;
  assign ex_mem_regwrite = slot_writes(w_mem);
  assign ex_mem_rd       = w_mem.rd;
  assign mem_wb_regwrite = slot_writes(w_wb);
  assign mem_wb_rd       = w_wb.rd;
  assign stall_count     = r_stall_count;

  assign w_unused = ^{w_mem.is_load, w_wb.is_load};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed instruction sequences with
// queued expectations, plus a long run that drives the stall counter to saturation.
module tb_hazard_scoreboard;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2, id_regwrite, id_is_load;
  logic        flush, freeze;
  logic        stall, ex_mem_regwrite, mem_wb_regwrite;
  logic [4:0]  ex_mem_rd, mem_wb_rd;
  logic [15:0] stall_count;

  typedef struct packed {
    logic        stall;
    logic        exm_rw;
    logic [4:0]  exm_rd;
    logic        mwb_rw;
    logic [4:0]  mwb_rd;
    logic [15:0] cnt;
  } obs_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic       fl;
    logic       fz;
  } stim_t;

  typedef struct {
    string name;
    obs_t  v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  hazard_scoreboard dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_rd           (id_rd),
    .id_regwrite     (id_regwrite),
    .id_is_load      (id_is_load),
    .flush           (flush),
    .freeze          (freeze),
    .stall           (stall),
    .ex_mem_regwrite (ex_mem_regwrite),
    .ex_mem_rd       (ex_mem_rd),
    .mem_wb_regwrite (mem_wb_regwrite),
    .mem_wb_rd       (mem_wb_rd),
    .stall_count     (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(input logic v, input logic [4:0] rd, input logic rw,
                               input logic ld, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2);
    stim_t s;
    s = '{v: v, rd: rd, rw: rw, ld: ld, rs1: rs1, u1: u1, rs2: rs2, u2: u2,
          fl: 1'b0, fz: 1'b0};
    return s;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o = {stall, ex_mem_regwrite, ex_mem_rd, mem_wb_regwrite, mem_wb_rd, stall_count};
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("stall=%b exm=%b/%0d mwb=%b/%0d cnt=%0d",
                     o.stall, o.exm_rw, o.exm_rd, o.mwb_rw, o.mwb_rd, o.cnt);
  endfunction

  task automatic push_exp(input string n, input logic s, input logic er,
                          input logic [4:0] ed, input logic wr, input logic [4:0] wd,
                          input logic [15:0] c);
    exp_t e;
    e.name = n;
    e.v    = {s, er, ed, wr, wd, c};
    sb.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    id_valid    = s.v;
    id_rd       = s.rd;
    id_regwrite = s.rw;
    id_is_load  = s.ld;
    id_rs1      = s.rs1;
    id_uses_rs1 = s.u1;
    id_rs2      = s.rs2;
    id_uses_rs2 = s.u2;
    flush       = s.fl;
    freeze      = s.fz;
  endtask

  // Entered and left 1 time unit after a rising edge; observation sits mid-cycle.
  task automatic run_cycle(input stim_t s, output obs_t o);
    drive(s);
    #3;
    o = observe();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive('0);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  stim_t s_ld5, s_use5, s_add5, s_sub8, s_ldx0, s_use0, s_add3, s_bub;

  task automatic test_reset();
    obs_t o;
    exp_t e;
    drive(s_ld5);
    reset = 1'b1;
    #2;
    push_exp("reset_async", 0, 0, 0, 0, 0, 16'd0);
    o = observe();
    e = sb.pop_front();
    n_cmp++;
    if (o !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %s, expected %s", e.name, fmt(o), fmt(e.v));
    end
    @(posedge clk);
    #1;
    push_exp("reset_held_over_edge", 0, 0, 0, 0, 0, 16'd0);
    o = observe();
    e = sb.pop_front();
    n_cmp++;
    if (o !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %s, expected %s", e.name, fmt(o), fmt(e.v));
    end
    reset = 1'b0;
    drive(s_bub);
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use();
    stim_t st[$];
    obs_t  o;
    exp_t  e;
    apply_reset();
    st.push_back(s_ld5);  push_exp("lu_load_in_id",   0, 0, 0, 0, 0, 16'd0);
    st.push_back(s_use5); push_exp("lu_stall",        1, 0, 0, 0, 0, 16'd0);
    st.push_back(s_use5); push_exp("lu_load_in_mem",  0, 1, 5, 0, 0, 16'd1);
    st.push_back(s_bub);  push_exp("lu_load_in_wb",   0, 0, 0, 1, 5, 16'd1);
    st.push_back(s_bub);  push_exp("lu_consumer_mem", 0, 1, 6, 0, 0, 16'd1);
    foreach (st[i]) begin
      run_cycle(st[i], o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %s, expected %s", e.name, fmt(o), fmt(e.v));
      end
    end
  endtask

  task automatic test_non_load();
    stim_t st[$];
    obs_t  o;
    exp_t  e;
    apply_reset();
    st.push_back(s_add5); push_exp("nl_add_in_id",  0, 0, 0, 0, 0, 16'd0);
    st.push_back(s_sub8); push_exp("nl_no_stall",   0, 0, 0, 0, 0, 16'd0);
    st.push_back(s_bub);  push_exp("nl_add_in_mem", 0, 1, 5, 0, 0, 16'd0);
    st.push_back(s_bub);  push_exp("nl_add_in_wb",  0, 1, 8, 1, 5, 16'd0);
    foreach (st[i]) begin
      run_cycle(st[i], o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %s, expected %s", e.name, fmt(o), fmt(e.v));
      end
    end
  endtask

  task automatic test_x0();
    stim_t st[$];
    obs_t  o;
    exp_t  e;
    apply_reset();
    st.push_back(s_ldx0); push_exp("x0_load_in_id",   0, 0, 0, 0, 0, 16'd0);
    st.push_back(s_use0); push_exp("x0_no_stall",     0, 0, 0, 0, 0, 16'd0);
    st.push_back(s_bub);  push_exp("x0_no_regwrite",  0, 0, 0, 0, 0, 16'd0);
    st.push_back(s_bub);  push_exp("x0_consumer_mem", 0, 1, 9, 0, 0, 16'd0);
    foreach (st[i]) begin
      run_cycle(st[i], o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %s, expected %s", e.name, fmt(o), fmt(e.v));
      end
    end
  endtask

  task automatic test_stall_flush();
    stim_t st[$];
    stim_t s;
    obs_t  o;
    exp_t  e;
    apply_reset();
    s    = s_use5;
    s.fl = 1'b1;
    st.push_back(s_ld5); push_exp("sf_load_in_id",    0, 0, 0, 0, 0, 16'd0);
    st.push_back(s);     push_exp("sf_stall_flush",   1, 0, 0, 0, 0, 16'd0);
    st.push_back(s_bub); push_exp("sf_load_advances", 0, 1, 5, 0, 0, 16'd0);
    st.push_back(s_bub); push_exp("sf_single_bubble", 0, 0, 0, 1, 5, 16'd0);
    st.push_back(s_bub); push_exp("sf_consumer_gone", 0, 0, 0, 0, 0, 16'd0);
    foreach (st[i]) begin
      run_cycle(st[i], o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %s, expected %s", e.name, fmt(o), fmt(e.v));
      end
    end
  endtask

  task automatic test_freeze();
    stim_t st[$];
    stim_t s;
    obs_t  o;
    exp_t  e;
    apply_reset();
    s    = s_use5;
    s.fz = 1'b1;
    st.push_back(s_add3); push_exp("fz_add_in_id",   0, 0, 0, 0, 0, 16'd0);
    st.push_back(s_ld5);  push_exp("fz_load_in_id",  0, 0, 0, 0, 0, 16'd0);
    for (int k = 0; k < 3; k++) begin
      st.push_back(s);
      push_exp($sformatf("fz_hold%0d", k), 1, 1, 3, 0, 0, 16'd0);
    end
    st.push_back(s_use5); push_exp("fz_release",     1, 1, 3, 0, 0, 16'd0);
    st.push_back(s_use5); push_exp("fz_after_stall", 0, 1, 5, 1, 3, 16'd1);
    st.push_back(s_bub);  push_exp("fz_load_in_wb",  0, 0, 0, 1, 5, 16'd1);
    st.push_back(s_bub);  push_exp("fz_consumer",    0, 1, 6, 0, 0, 16'd1);
    foreach (st[i]) begin
      run_cycle(st[i], o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %s, expected %s", e.name, fmt(o), fmt(e.v));
      end
    end
  endtask

  // A load of x5 that also reads x5 stalls on every other cycle forever.
  task automatic test_saturation();
    stim_t       s;
    obs_t        o;
    exp_t        e;
    bit          m_ex, m_mem, m_wb, m_st;
    logic [15:0] m_cnt;
    int          stall_edges, cyc;
    apply_reset();
    s           = mk(1, 5, 1, 1, 5, 1, 0, 0);
    m_ex        = 0;
    m_mem       = 0;
    m_wb        = 0;
    m_cnt       = 16'd0;
    stall_edges = 0;
    cyc         = 0;
    while (!(stall_edges >= 65540 && m_ex)) begin
      drive(s);
      #3;
      m_st = m_ex;
      if (cyc < 6 || m_cnt >= 16'hFFFD) begin
        push_exp($sformatf("sat_cyc%0d", cyc), m_st, m_mem, m_mem ? 5'd5 : 5'd0,
                 m_wb, m_wb ? 5'd5 : 5'd0, m_cnt);
        o = observe();
        e = sb.pop_front();
        n_cmp++;
        if (o !== e.v) begin
          n_bad++;
          $display("FAIL %s: got %s, expected %s", e.name, fmt(o), fmt(e.v));
        end
      end
      @(posedge clk);
      #1;
      if (m_st) begin
        stall_edges++;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = !m_st;
      cyc++;
    end
    #2;
    reset = 1'b1;
    #1;
    push_exp("sat_async_reset", 0, 0, 0, 0, 0, 16'd0);
    o = observe();
    e = sb.pop_front();
    n_cmp++;
    if (o !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %s, expected %s", e.name, fmt(o), fmt(e.v));
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    #3;
    push_exp("sat_restart_empty", 1, 0, 0, 0, 0, 16'd0);
    o = observe();
    e = sb.pop_front();
    n_cmp++;
    if (o !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %s, expected %s", e.name, fmt(o), fmt(e.v));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    s_ld5  = mk(1, 5, 1, 1, 1, 1, 0, 0);
    s_use5 = mk(1, 6, 1, 0, 5, 1, 7, 1);
    s_add5 = mk(1, 5, 1, 0, 1, 1, 2, 1);
    s_sub8 = mk(1, 8, 1, 0, 5, 1, 5, 1);
    s_ldx0 = mk(1, 0, 1, 1, 1, 1, 0, 0);
    s_use0 = mk(1, 9, 1, 0, 0, 1, 0, 0);
    s_add3 = mk(1, 3, 1, 0, 1, 1, 2, 1);
    s_bub  = '0;
    reset  = 1'b1;
    drive(s_bub);

    test_reset();
    test_load_use();
    test_non_load();
    test_x0();
    test_stall_flush();
    test_freeze();
    test_saturation();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
